int_datapath_mdu: RTL and testbench

Parametrised integer datapath: register file, T-mux, single-cycle ALU, Y-mux and an iterative multiply/divide unit (MDU) that writes the HI/LO registers. It is the next-generation integer execution core for the CECS 440 processor. A control unit drives it each cycle. Multiply and divide are multi-cycle through a start/busy/done handshake, not single-cycle, so ALU, register-file and Y-mux traffic continues while the MDU runs.

---
 rtl/int_datapath_mdu.sv | 147 ++++++++++++++
 tb/tb_int_datapath_mdu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int_datapath_mdu.sv
// int_datapath_mdu: register file, T-mux, ALU, Y-mux and iterative multiply/divide unit
module int_datapath_mdu #(
  parameter int WIDTH = 32,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREG)-1:0]  s_addr,
  input  logic [$clog2(NREG)-1:0]  t_addr,
  input  logic [$clog2(NREG)-1:0]  d_addr,
  input  logic                     d_en,
  input  logic [WIDTH-1:0]         dt,
  input  logic                     t_sel,
  input  logic [3:0]               fs,
  input  logic [WIDTH-1:0]         dy,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [2:0]               y_sel,
  input  logic                     md_start,
  input  logic [1:0]               md_op,
  output logic                     md_busy,
  output logic                     md_done,
  output logic                     div_by_zero,
  output logic [WIDTH-1:0]         alu_out,
  output logic [WIDTH-1:0]         d_out,
  output logic                     c,
  output logic                     v,
  output logic                     n,
  output logic                     z
);
  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] s, t, res, hi, lo, a_mag, b_mag, b, q, r, res_hi, res_lo;
  logic [WIDTH:0] add_r, sub_r, mul_sum, rem, rem2;
  logic [2*WIDTH-1:0] p, p_nx, mul_nx, div_nx, prod;
  logic [CW-1:0] cnt;
  logic op_div, neg_q, neg_r, dbz, s_neg, t_neg, div0, start_ok, ge;
  assign s = s_addr == '0 ? '0 : rf[s_addr];
  assign t = t_sel ? dt : (t_addr == '0 ? '0 : rf[t_addr]);
  assign d_out = t;
  assign add_r = {1'b0, s} + {1'b0, t};
  assign sub_r = {1'b0, s} + {1'b0, ~t} + (WIDTH+1)'(1);
  // ALU function decode and flags
  always_comb begin
    res = '0;
    case (fs)
      4'h0: res = s;
      4'h1: res = t;
      4'h2: res = add_r[WIDTH-1:0];
      4'h3: res = sub_r[WIDTH-1:0];
      4'h4: res = s & t;
      4'h5: res = s | t;
      4'h6: res = s ^ t;
      4'h7: res = ~(s | t);
      4'h8: res = WIDTH'($signed(s) < $signed(t));
      4'h9: res = WIDTH'(s < t);
      4'hA: res = t << s[LW-1:0];
      4'hB: res = t >> s[LW-1:0];
      4'hC: res = $signed(t) >>> s[LW-1:0];
      default: res = '0;
    endcase
    c = fs == 4'h2 ? add_r[WIDTH] : fs == 4'h3 ? sub_r[WIDTH] : 1'b0;
    v = fs == 4'h2 ? (s[WIDTH-1] == t[WIDTH-1]) && (res[WIDTH-1] != s[WIDTH-1]) :
        fs == 4'h3 ? (s[WIDTH-1] != t[WIDTH-1]) && (res[WIDTH-1] != s[WIDTH-1]) : 1'b0;
    n = res[WIDTH-1];
    z = res == '0;
  end
  // Y-mux: PC, memory data, LO, HI, otherwise ALU result
  always_comb begin
    alu_out = y_sel == 3'd0 ? pc_in : y_sel == 3'd1 ? dy : y_sel == 3'd3 ? lo :
              y_sel == 3'd4 ? hi : res;
  end
  // Register file write; r0 is never stored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (d_en && d_addr != '0) rf[d_addr] <= alu_out;
  end
  // MDU operand conditioning and one iteration step (shift-add or restoring subtract)
  always_comb begin
    s_neg = md_op[0] & s[WIDTH-1];
    t_neg = md_op[0] & t[WIDTH-1];
    a_mag = s_neg ? -s : s;
    b_mag = t_neg ? -t : t;
    div0 = md_op[1] && t == '0;
    start_ok = md_start && state != RUN;
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, b} : '0);
    mul_nx = {mul_sum, p[WIDTH-1:1]};
    rem = p[2*WIDTH-1:WIDTH-1];
    ge = rem >= {1'b0, b};
    rem2 = ge ? rem - {1'b0, b} : rem;
    div_nx = {rem2[WIDTH-1:0], p[WIDTH-2:0], ge};
    p_nx = op_div ? div_nx : mul_nx;
    prod = neg_q ? -p_nx : p_nx;
    q = p_nx[WIDTH-1:0];
    r = p_nx[2*WIDTH-1:WIDTH];
    res_hi = op_div ? (neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
    res_lo = op_div ? (neg_q ? -q : q) : prod[WIDTH-1:0];
  end
  // MDU state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // MDU next state and handshake outputs
  always_comb begin
    state_n = start_ok ? (div0 ? DONE : RUN) :
              state == RUN ? (cnt == CW'(1) ? DONE : RUN) : IDLE;
    md_busy = state == RUN;
    md_done = state == DONE;
    div_by_zero = md_done & dbz;
  end
  // MDU datapath: capture operands at start, iterate, load HI/LO on the last step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
      b <= '0;
      cnt <= '0;
      op_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dbz <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (start_ok) begin
      p <= {{WIDTH{1'b0}}, a_mag};
      b <= b_mag;
      cnt <= CW'(WIDTH);
      op_div <= md_op[1];
      neg_q <= s_neg ^ t_neg;
      neg_r <= s_neg;
      dbz <= div0;
      if (div0) begin
        hi <= s;
        lo <= '1;
      end
    end else if (state == RUN) begin
      p <= p_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_int_datapath_mdu.sv
// tb_int_datapath_mdu: table-driven ALU checks plus directed MDU sequences
module tb_int_datapath_mdu;
  logic clk = 0, reset = 1;
  logic [4:0] s_addr = 0, t_addr = 0, d_addr = 0;
  logic d_en = 0, t_sel = 0, md_start = 0;
  logic [31:0] dt = 0, dy = 0, pc_in = 0;
  logic [3:0] fs = 0;
  logic [2:0] y_sel = 0;
  logic [1:0] md_op = 0;
  logic md_busy, md_done, div_by_zero, c, v, n, z;
  logic [31:0] alu_out, d_out;
  int checks = 0, failures = 0;
  logic [31:0] prev_lo = 0;
  typedef struct {
    logic [31:0] s;
    logic [31:0] t;
    logic [3:0] fs;
    logic [31:0] y;
    logic [3:0] f;
  } vec_t;
  vec_t tbl[17];
  int_datapath_mdu #(.WIDTH(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .t_addr(t_addr), .d_addr(d_addr),
    .d_en(d_en), .dt(dt), .t_sel(t_sel), .fs(fs), .dy(dy), .pc_in(pc_in),
    .y_sel(y_sel), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .md_done(md_done), .div_by_zero(div_by_zero), .alu_out(alu_out), .d_out(d_out),
    .c(c), .v(v), .n(n), .z(z)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] val);
    d_addr = a; dt = val; t_sel = 1; fs = 4'h1; y_sel = 3'd2; d_en = 1;
    tick();
    d_en = 0;
  endtask
  task automatic rd_hilo(input string nm, input logic [31:0] hi_e, input logic [31:0] lo_e);
    y_sel = 3'd3; #1;
    chk({nm, "_lo"}, alu_out, lo_e);
    y_sel = 3'd4; #1;
    chk({nm, "_hi"}, alu_out, hi_e);
  endtask
  task automatic wait_done(output int busy);
    busy = 0;
    for (int i = 0; i < 100 && !md_done; i++) begin
      busy += int'(md_busy);
      tick();
    end
    chk("done_seen", md_done, 1);
  endtask
  task automatic run_md(input logic [1:0] op, input logic [31:0] sv, input logic [31:0] tv,
                        input logic [31:0] hi_e, input logic [31:0] lo_e, input string nm);
    int busy;
    wr(1, sv);
    wr(2, tv);
    s_addr = 1; t_addr = 2; t_sel = 0; md_op = op; md_start = 1;
    tick();
    md_start = 0;
    y_sel = 3'd3; #1;
    chk({nm, "_lo_held"}, alu_out, prev_lo);
    wait_done(busy);
    chk({nm, "_busy_cycles"}, busy, 32);
    chk({nm, "_busy_in_done"}, md_busy, 0);
    rd_hilo(nm, hi_e, lo_e);
    chk({nm, "_dbz"}, div_by_zero, 0);
    prev_lo = lo_e;
    tick();
  endtask
  initial begin
    int busy, b2, dones;
    tbl[0]  = '{32'h7FFFFFFF, 32'h1,        4'h2, 32'h80000000, 4'b0110};
    tbl[1]  = '{32'h5,        32'h5,        4'h3, 32'h0,        4'b1001};
    tbl[2]  = '{32'h3,        32'h5,        4'h3, 32'hFFFFFFFE, 4'b0010};
    tbl[3]  = '{32'hFFFFFFFF, 32'h1,        4'h2, 32'h0,        4'b1001};
    tbl[4]  = '{32'h80000000, 32'h1,        4'h3, 32'h7FFFFFFF, 4'b1100};
    tbl[5]  = '{32'hF0F0,     32'hFF00,     4'h4, 32'hF000,     4'b0000};
    tbl[6]  = '{32'hF0F0,     32'hFF00,     4'h5, 32'hFFF0,     4'b0000};
    tbl[7]  = '{32'hF0F0,     32'hFF00,     4'h6, 32'h0FF0,     4'b0000};
    tbl[8]  = '{32'h0,        32'h0,        4'h7, 32'hFFFFFFFF, 4'b0010};
    tbl[9]  = '{32'hFFFFFFFF, 32'h1,        4'h8, 32'h1,        4'b0000};
    tbl[10] = '{32'hFFFFFFFF, 32'h1,        4'h9, 32'h0,        4'b0001};
    tbl[11] = '{32'h24,       32'h1,        4'hA, 32'h10,       4'b0000};
    tbl[12] = '{32'h4,        32'h80000000, 4'hB, 32'h08000000, 4'b0000};
    tbl[13] = '{32'h4,        32'h80000000, 4'hC, 32'hF8000000, 4'b0010};
    tbl[14] = '{32'h1234,     32'hABCD,     4'h0, 32'h1234,     4'b0000};
    tbl[15] = '{32'h1234,     32'hABCD,     4'h1, 32'hABCD,     4'b0000};
    tbl[16] = '{32'h1234,     32'hABCD,     4'hD, 32'h0,        4'b0001};
    repeat (2) tick();
    reset = 0;
    tick();
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_dbz", div_by_zero, 0);
    rd_hilo("rst", 0, 0);
    wr(1, 5);
    wr(2, 3);
    s_addr = 1; t_addr = 2; t_sel = 0; md_op = 2'b01; md_start = 1;
    tick();
    md_start = 0;
    repeat (5) tick();
    chk("mid_busy", md_busy, 1);
    reset = 1; #3; reset = 0; #1;
    chk("abort_busy", md_busy, 0);
    fs = 4'h0; y_sel = 3'd2; #1;
    chk("abort_r1", alu_out, 0);
    t_sel = 0; #1;
    chk("abort_r2", d_out, 0);
    rd_hilo("abort", 0, 0);
    dones = 0;
    repeat (40) begin
      dones += int'(md_done);
      tick();
    end
    chk("abort_no_done", dones, 0);
    foreach (tbl[i]) begin
      wr(1, tbl[i].s);
      s_addr = 1; t_sel = 1; dt = tbl[i].t; fs = tbl[i].fs; y_sel = 3'd2; #1;
      chk($sformatf("alu%0d_y", i), alu_out, tbl[i].y);
      chk($sformatf("alu%0d_flags", i), {c, v, n, z}, tbl[i].f);
      chk($sformatf("alu%0d_dout", i), d_out, tbl[i].t);
    end
    wr(0, 32'h99);
    s_addr = 0; fs = 4'h0; y_sel = 3'd2; #1;
    chk("r0_write", alu_out, 0);
    wr(3, 32'h55);
    t_addr = 3; t_sel = 0; #1;
    chk("tmux_reg", d_out, 32'h55);
    d_addr = 3; dt = 32'h77; t_sel = 1; fs = 4'h1; d_en = 1; s_addr = 3; #1;
    t_sel = 1; fs = 4'h0; #1;
    chk("wr_rd_old", alu_out, 32'h55);
    d_en = 0;
    y_sel = 3'd0; pc_in = 32'hCAFE0000; #1;
    chk("ymux_pc", alu_out, 32'hCAFE0000);
    y_sel = 3'd1; dy = 32'h1234ABCD; #1;
    chk("ymux_dy", alu_out, 32'h1234ABCD);
    y_sel = 3'd6; #1;
    chk("ymux_6", alu_out, 32'h55);
    run_md(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult");
    run_md(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, "multu");
    run_md(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_md(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
    run_md(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_min");
    wr(1, 9);
    wr(2, 0);
    s_addr = 1; t_addr = 2; t_sel = 0; md_op = 2'b10; md_start = 1;
    tick();
    md_start = 0;
    chk("dz_done", md_done, 1);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_busy", md_busy, 0);
    rd_hilo("dz", 32'd9, 32'hFFFFFFFF);
    tick();
    chk("dz_done_clear", md_done, 0);
    wr(1, 6);
    wr(2, 7);
    s_addr = 1; t_addr = 2; t_sel = 0; md_op = 2'b00; md_start = 1;
    tick();
    md_start = 0;
    busy = 0;
    repeat (3) begin
      busy += int'(md_busy);
      tick();
    end
    d_addr = 1; dt = 32'd100; t_sel = 1; fs = 4'h1; y_sel = 3'd2; d_en = 1;
    md_op = 2'b10; md_start = 1;
    busy += int'(md_busy);
    tick();
    d_addr = 2; dt = 32'd3;
    busy += int'(md_busy);
    tick();
    d_en = 0; md_start = 0; t_sel = 0;
    wait_done(b2);
    chk("ovl_busy_cycles", busy + b2, 32);
    rd_hilo("ovl", 0, 32'd42);
    md_op = 2'b00; md_start = 1;
    tick();
    md_start = 0;
    chk("b2b_busy", md_busy, 1);
    chk("b2b_done_clear", md_done, 0);
    wait_done(b2);
    chk("b2b_busy_cycles", b2, 32);
    rd_hilo("b2b", 0, 32'd300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
